// File: rtl/mcu_pixel_port.sv
// rtl/mcu_pixel_port.sv - MCU register port feeding a pixel write queue to a memory handshake
// Auto-increment of X/Y after DATA writes is built only when MCU_PIXEL_PORT_AUTOINC_EN is defined.
module mcu_pixel_port #(
  parameter int X_BITS     = 9,
  parameter int Y_BITS     = 8,
  parameter int X_LIMIT    = 320,
  parameter int Y_LIMIT    = 240,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic [X_BITS+Y_BITS-1:0] memoryAddress,
  output logic [7:0]               memoryWriteData,
  output logic                     memoryWriteRequest,
  input  logic                     memoryWriteComplete,
  input  logic                     mpuChipSelect,
  input  logic                     mpuWriteEnable,
  input  logic [2:0]               mpuRegisterSelect,
  inout  wire  [7:0]               mpuDataBus
);

  localparam int AW = X_BITS + Y_BITS;
  localparam int EW = AW + 8;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mcu_pixel_port: FIFO_DEPTH must be a power of two >= 2");
  end
  if (X_LIMIT < 1 || X_LIMIT > (1 << X_BITS) || Y_LIMIT < 1 || Y_LIMIT > (1 << Y_BITS)) begin : g_bad_limit
    $error("mcu_pixel_port: X_LIMIT/Y_LIMIT out of coordinate range");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_GAP} state_t;

  state_t              state_q, state_d;
  logic                wr_s1_q, wr_s1_d, wr_s2_q, wr_s2_d, wr_h_q, wr_h_d;
  logic                rd_s1_q, rd_s1_d, rd_s2_q, rd_s2_d, rd_h_q, rd_h_d;
  logic [2:0]          reg_hold_q, reg_hold_d;
  logic [7:0]          data_hold_q, data_hold_d;
  logic [X_BITS-1:0]   x_q, x_d;
  logic [Y_BITS-1:0]   y_q, y_d;
  logic                ovf_q, ovf_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [EW-1:0]       fifo_q [FIFO_DEPTH];
  logic [EW-1:0]       fifo_d [FIFO_DEPTH];
`ifdef MCU_PIXEL_PORT_AUTOINC_EN
  logic                auto_q, auto_d;
`endif

  logic                commit, push, push_ok, pop, empty, full, busy;
  logic [15:0]         x_wr, x_ext;
  logic [EW-1:0]       head;
  logic [7:0]          rd_data;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign head  = fifo_q[rd_ptr_q];
  assign busy  = memoryWriteRequest || !empty;

  assign memoryWriteRequest = (state_q == ST_REQ);
  // Outputs are zeroed whenever nothing is queued so stale slots never reach memory.
  assign memoryAddress      = empty ? '0 : head[EW-1:8];
  assign memoryWriteData    = empty ? '0 : head[7:0];

  always_comb begin
    wr_s1_d     = mpuChipSelect && !mpuWriteEnable;
    wr_s2_d     = wr_s1_q;
    wr_h_d      = wr_s2_q;
    rd_s1_d     = mpuChipSelect && mpuWriteEnable;
    rd_s2_d     = rd_s1_q;
    rd_h_d      = rd_s2_q;
    reg_hold_d  = wr_s2_q ? mpuRegisterSelect : reg_hold_q;
    data_hold_d = wr_s2_q ? mpuDataBus : data_hold_q;
    commit      = wr_h_q && !wr_s2_q;
    x_wr        = {data_hold_q, x_q[7:0]};
    x_d         = x_q;
    y_d         = y_q;
    ovf_d       = ovf_q;
    push        = 1'b0;
    pop         = 1'b0;
    state_d     = state_q;
`ifdef MCU_PIXEL_PORT_AUTOINC_EN
    auto_d      = auto_q;
`endif

    case (state_q)
      ST_IDLE: if (!empty) state_d = ST_REQ;
      ST_REQ: begin
        if (memoryWriteComplete) begin
          pop     = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (rd_s2_q && !rd_h_q && mpuRegisterSelect == 3'd5) ovf_d = 1'b0;

    if (commit) begin
      case (reg_hold_q)
        3'd0: x_d = {x_q[X_BITS-1:8], data_hold_q};
        3'd1: x_d = x_wr[X_BITS-1:0];
        3'd2: y_d = data_hold_q[Y_BITS-1:0];
        3'd3: begin
          push = 1'b1;
          if (full && !pop) ovf_d = 1'b1;
`ifdef MCU_PIXEL_PORT_AUTOINC_EN
          if (auto_q) begin
            if (x_q == X_BITS'(X_LIMIT - 1)) begin
              x_d = '0;
              y_d = (y_q == Y_BITS'(Y_LIMIT - 1)) ? '0 : y_q + Y_BITS'(1);
            end else begin
              x_d = x_q + X_BITS'(1);
            end
          end
`endif
        end
        3'd4: begin
`ifdef MCU_PIXEL_PORT_AUTOINC_EN
          auto_d = data_hold_q[0];
`endif
          if (data_hold_q[1]) ovf_d = 1'b0;
        end
        default: ;
      endcase
    end

    // A pop in the same cycle frees the slot, so a full-queue push still lands.
    push_ok = push && (!full || pop);
    fifo_d  = fifo_q;
    if (push_ok) fifo_d[wr_ptr_q] = {y_q, x_q, data_hold_q};
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop) count_d = count_q + CW'(1);
    else if (!push_ok && pop) count_d = count_q - CW'(1);
  end

  always_comb begin
    x_ext   = 16'(x_q);
    rd_data = 8'h00;
    case (mpuRegisterSelect)
      3'd0: rd_data = x_ext[7:0];
      3'd1: rd_data = x_ext[15:8];
      3'd2: rd_data = 8'(y_q);
`ifdef MCU_PIXEL_PORT_AUTOINC_EN
      3'd4: rd_data = {7'b0, auto_q};
`endif
      3'd5: rd_data = {4'b0, busy, ovf_q, full, empty};
      default: rd_data = 8'h00;
    endcase
  end

  assign mpuDataBus = (mpuChipSelect && mpuWriteEnable) ? rd_data : 8'hzz;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_s1_q     <= 1'b0;
      wr_s2_q     <= 1'b0;
      wr_h_q      <= 1'b0;
      rd_s1_q     <= 1'b0;
      rd_s2_q     <= 1'b0;
      rd_h_q      <= 1'b0;
      reg_hold_q  <= '0;
      data_hold_q <= '0;
      x_q         <= '0;
      y_q         <= '0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
`ifdef MCU_PIXEL_PORT_AUTOINC_EN
      auto_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_s1_q     <= wr_s1_d;
      wr_s2_q     <= wr_s2_d;
      wr_h_q      <= wr_h_d;
      rd_s1_q     <= rd_s1_d;
      rd_s2_q     <= rd_s2_d;
      rd_h_q      <= rd_h_d;
      reg_hold_q  <= reg_hold_d;
      data_hold_q <= data_hold_d;
      x_q         <= x_d;
      y_q         <= y_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
`ifdef MCU_PIXEL_PORT_AUTOINC_EN
      auto_q      <= auto_d;
`endif
    end
  end

  always_ff @(posedge clock) begin
    fifo_q <= fifo_d;
  end

endmodule

// File: tb/tb_mcu_pixel_port.sv
// tb/tb_mcu_pixel_port.sv - directed bench with a scoreboard of expected memory writes
module tb_mcu_pixel_port;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [16:0] memoryAddress;
  logic [7:0]  memoryWriteData;
  logic        memoryWriteRequest;
  logic        memoryWriteComplete = 1'b0;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  rs = 3'd0;
  wire  [7:0]  bus;
  logic [7:0]  tb_data = 8'h00;
  logic        tb_drv = 1'b1;

  int          tests = 0;
  int          fails = 0;
  logic [24:0] sb [$];
  logic [8:0]  mx = '0;
  logic [7:0]  my = '0;
  bit          mauto = 1'b0;
  bit          movf = 1'b0;

  always #5 clock = ~clock;
  assign bus = tb_drv ? tb_data : 8'hzz;

  mcu_pixel_port dut (
    .clock               (clock),
    .reset               (reset),
    .memoryAddress       (memoryAddress),
    .memoryWriteData     (memoryWriteData),
    .memoryWriteRequest  (memoryWriteRequest),
    .memoryWriteComplete (memoryWriteComplete),
    .mpuChipSelect       (cs),
    .mpuWriteEnable      (we),
    .mpuRegisterSelect   (rs),
    .mpuDataBus          (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] r, input logic [7:0] d, output logic req_e3);
    case (r)
      3'd0: mx = {mx[8], d};
      3'd1: mx = {d[0], mx[7:0]};
      3'd2: my = d;
      3'd3: begin
        if (sb.size() < 4) sb.push_back({my, mx, d});
        else movf = 1'b1;
        if (mauto) begin
          if (mx == 9'd319) begin
            mx = '0;
            my = (my == 8'd239) ? 8'd0 : my + 8'd1;
          end else begin
            mx = mx + 9'd1;
          end
        end
      end
      3'd4: begin
`ifdef MCU_PIXEL_PORT_AUTOINC_EN
        mauto = d[0];
`endif
        if (d[1]) movf = 1'b0;
      end
      default: ;
    endcase
    @(negedge clock);
    rs = r; tb_data = d; tb_drv = 1'b1; we = 1'b0; cs = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    cs = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    req_e3 = memoryWriteRequest;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic rd(input logic [2:0] r, output logic [7:0] v);
    @(negedge clock);
    tb_drv = 1'b0; rs = r; we = 1'b1; cs = 1'b1;
    #2 v = bus;
    repeat (3) @(posedge clock);
    @(negedge clock);
    cs = 1'b0; we = 1'b0; tb_drv = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    if (r == 3'd5) movf = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [2:0] r, input logic [7:0] exp);
    logic [7:0] v;
    rd(r, v);
    check(tag, 32'(v), 32'(exp));
  endtask

  function automatic logic [7:0] status_exp();
    return {4'b0, sb.size() != 0, movf, sb.size() == 4, sb.size() == 0};
  endfunction

  task automatic serve_one(input string tag);
    int n = 0;
    logic [24:0] e;
    while (!memoryWriteRequest && n < 50) begin
      @(negedge clock);
      n++;
    end
    check({tag, " req"}, 32'(memoryWriteRequest), 32'd1);
    e = (sb.size() > 0) ? sb.pop_front() : 25'h1ffffff;
    check({tag, " addr"}, 32'(memoryAddress), 32'(e[24:8]));
    check({tag, " data"}, 32'(memoryWriteData), 32'(e[7:0]));
    @(negedge clock);
    check({tag, " held"}, 32'({memoryWriteRequest, memoryAddress}), 32'({1'b1, e[24:8]}));
    memoryWriteComplete = 1'b1;
    @(negedge clock);
    memoryWriteComplete = 1'b0;
    check({tag, " gap"}, 32'(memoryWriteRequest), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r3;
    int   hits;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset req", 32'(memoryWriteRequest), 32'd0);
    check("reset addr", 32'(memoryAddress), 32'd0);
    check("reset data", 32'(memoryWriteData), 32'd0);
    reset = 1'b0;
    check_reg("reset status", 3'd5, 8'h01);
    check_reg("reset xlo", 3'd0, 8'h00);
    check_reg("reset y", 3'd2, 8'h00);

    wr(3'd0, 8'hFF, r3);
    wr(3'd1, 8'h01, r3);
    wr(3'd2, 8'h02, r3);
    wr(3'd3, 8'h03, r3);
    check("lat req before 2 clk", 32'(r3), 32'd0);
    check("lat req at 2 clk", 32'(memoryWriteRequest), 32'd1);
    check("basic addr", 32'(memoryAddress), 32'h005FF);
    check("basic data", 32'(memoryWriteData), 32'h03);
    serve_one("basic");
    check("basic addr cleared", 32'(memoryAddress), 32'd0);
    check("basic data cleared", 32'(memoryWriteData), 32'd0);
    check_reg("basic xlo", 3'd0, 8'hFF);
    check_reg("basic xhi", 3'd1, 8'h01);
    check_reg("basic status", 3'd5, status_exp());

`ifdef MCU_PIXEL_PORT_AUTOINC_EN
    wr(3'd4, 8'h01, r3);
    check_reg("ctrl on", 3'd4, 8'h01);
    wr(3'd0, 8'h3E, r3);
    wr(3'd1, 8'h01, r3);
    wr(3'd2, 8'h00, r3);
    wr(3'd3, 8'h0A, r3);
    wr(3'd3, 8'h0B, r3);
    wr(3'd3, 8'h0C, r3);
    check("ai addr0", 32'(sb[0][24:8]), 32'h0013E);
    check("ai addr2", 32'(sb[2][24:8]), 32'h00200);
    serve_one("ai px0");
    serve_one("ai px1");
    serve_one("ai px2");
    check_reg("ai xlo", 3'd0, 8'h01);
    check_reg("ai xhi", 3'd1, 8'h00);
    check_reg("ai y", 3'd2, 8'h01);
    wr(3'd0, 8'h3F, r3);
    wr(3'd1, 8'h01, r3);
    wr(3'd2, 8'hEF, r3);
    wr(3'd3, 8'h07, r3);
    check("wrap addr", 32'(memoryAddress), 32'h1DF3F);
    serve_one("wrap px");
    check_reg("wrap xlo", 3'd0, 8'h00);
    check_reg("wrap xhi", 3'd1, 8'h00);
    check_reg("wrap y", 3'd2, 8'h00);
    wr(3'd4, 8'h00, r3);
`else
    wr(3'd4, 8'h01, r3);
    check_reg("ctrl bit0 off", 3'd4, 8'h00);
    wr(3'd0, 8'h3E, r3);
    wr(3'd1, 8'h01, r3);
    wr(3'd2, 8'h00, r3);
    wr(3'd3, 8'h0A, r3);
    wr(3'd3, 8'h0B, r3);
    check("noai addr1", 32'(sb[1][24:8]), 32'h0013E);
    serve_one("noai px0");
    serve_one("noai px1");
    check_reg("noai xlo", 3'd0, 8'h3E);
    check_reg("noai xhi", 3'd1, 8'h01);
`endif

    wr(3'd2, 8'h07, r3);
    for (int i = 0; i < 5; i++) begin
      wr(3'd0, 8'(8'h10 + i), r3);
      wr(3'd3, 8'(8'h20 + i), r3);
    end
    check("ovf queued", 32'(sb.size()), 32'd4);
    check_reg("ovf status", 3'd5, 8'h0E);
    check_reg("ovf cleared", 3'd5, status_exp());
    for (int i = 0; i < 4; i++) serve_one($sformatf("drain%0d", i));
    check_reg("drain status", 3'd5, 8'h01);

    @(negedge clock);
    memoryWriteComplete = 1'b1;
    @(negedge clock);
    memoryWriteComplete = 1'b0;
    check_reg("stray ack status", 3'd5, 8'h01);

    for (int i = 0; i < 3; i++) wr(3'd3, 8'(8'h40 + i), r3);
    check("rst pre req", 32'(memoryWriteRequest), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rst drops req", 32'(memoryWriteRequest), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    sb.delete();
    mx = '0; my = '0; mauto = 1'b0; movf = 1'b0;
    check_reg("rst status", 3'd5, 8'h01);
    check_reg("rst y", 3'd2, 8'h00);
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (memoryWriteRequest) hits++;
    end
    check("rst no requests", 32'(hits), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mcu_pixel_port.md
MCU_PIXEL_PORT -- requirements
Module: mcu_pixel_port

Interface
REQ-001 SHALL have parameter X_BITS, default 9, X coordinate width (9..16).
REQ-002 SHALL have parameter Y_BITS, default 8, Y coordinate width (1..8).
REQ-003 SHALL have parameter X_LIMIT, default 320, pixels per row (auto-increment wrap point).
REQ-004 SHALL have parameter Y_LIMIT, default 240, rows per frame (auto-increment wrap point).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, pixel write queue entries (power of two, >=2).
REQ-006 SHALL have ports: clock  in  1  sole clock; reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports: memoryAddress  out  X_BITS+Y_BITS  {Y,X} of queue head; memoryWriteData  out  8  pixel of queue head; memoryWriteRequest  out  1  write request; memoryWriteComplete  in  1  one-cycle acknowledge.
REQ-008 SHALL have ports: mpuChipSelect  in  1  bus select; mpuWriteEnable  in  1  0=write, 1=read; mpuRegisterSelect  in  3  register index; mpuDataBus  inout  8  MCU data.

Function
REQ-009 SHALL treat mpuChipSelect&&!mpuWriteEnable as write strobe and mpuChipSelect&&mpuWriteEnable as read strobe (both asynchronous to clock).
REQ-010 SHALL pass write strobe through a 2-flop synchronizer plus one history flop; a commit event is the synchronized strobe's 1->0 transition.
REQ-011 SHALL sample mpuRegisterSelect and mpuDataBus into holding registers every cycle the synchronized strobe is 1; commit uses held values.
REQ-012 SHALL map writes: 0 X[7:0]; 1 X[X_BITS-1:8]; 2 Y; 3 DATA (push {Y,X,data}); 4 CONTROL (bit0 auto-increment enable, bit1=1 clears overflow); 5-7 ignored.
REQ-013 SHALL drive mpuDataBus only while read strobe is asserted (combinational mux, else Z): 0 X[7:0]; 1 X high bits zero-extended; 2 Y; 4 CONTROL; 5 STATUS {4'b0,busy,overflow,full,empty}; 3,6,7 read 0.
REQ-014 SHALL clear overflow on the first clock the synchronized read strobe is 1 with register 5 selected.
REQ-015 SHALL, on DATA commit with queue full, drop the pixel, set sticky overflow, and still apply auto-increment.
REQ-016 SHALL, with auto-increment enabled, advance after every DATA commit: X+1; if X==X_LIMIT-1 then X=0 and Y+1; if also Y==Y_LIMIT-1 then Y=0.
REQ-017 SHALL, for a DATA commit, push address as it stood before increment.
REQ-018 SHALL implement memory side as states IDLE, REQ, GAP: IDLE->REQ when queue non-empty (request high next cycle); REQ holds request and head stable until memoryWriteComplete sampled 1, then pops and ->GAP; GAP drops request one cycle ->IDLE.
REQ-019 SHALL ignore memoryWriteComplete outside REQ.
REQ-020 SHALL allow push and pop in the same cycle; count unchanged, full-queue push then succeeds without overflow.
REQ-021 SHALL wrap queue pointers modulo FIFO_DEPTH; empty=count 0, full=count FIFO_DEPTH; busy=request high or queue non-empty.
REQ-022 SHALL give minimum latency commit->request high of 2 clocks with empty queue, idle FSM.

Reset
REQ-023 SHALL, on reset sampled high, clear X, Y, CONTROL, overflow, holding registers, synchronizer flops, queue pointers/count; FSM to IDLE.
REQ-024 SHALL hold memoryWriteRequest=0, memoryAddress=0, memoryWriteData=0 after reset; reset mid-REQ drops request at that edge and discards queued pixels.
REQ-025 SHALL suppress any commit whose falling edge straddles reset release (history flop cleared).

Configuration
REQ-026 SHALL compile auto-increment only when MCU_PIXEL_PORT_AUTOINC_EN is defined; undefined: CONTROL bit0 reads 0, writes to it ignored, X/Y change only by register writes.

Verification
REQ-027 Write X_LOW=0xFF, X_HIGH=1, Y=2, DATA=3 -> one request, memoryAddress=0x005FF, data 0x03, cleared after ack, GAP cycle observed.
REQ-028 AUTOINC_EN, CONTROL=1, X=318,Y=0; DATA 0xA,0xB,0xC -> addresses {0,318},{0,319},{1,0}; X/Y readback 1,1.
REQ-029 AUTOINC_EN, X=319,Y=239, DATA 0x7 -> pushed {239,319}; X,Y read 0,0.
REQ-030 Ack withheld; 5 DATA writes, FIFO_DEPTH=4 -> STATUS=0x0E; 5th dropped; STATUS read clears overflow; acks drain 4 pixels in order.
REQ-031 Reset asserted during REQ with 3 queued -> request low next edge; STATUS=0x01; no further requests.
